// File: rtl/freq_div_pkg.sv
// Shared constants and types for the multi-channel clock divider.
// Reset half-periods give 50/10/1 MHz outputs from a 100 MHz source clock.
package freq_div_pkg;

  localparam int CNT_W  = 8;
  localparam int NUM_CH = 3;

  localparam int RST_HALF_CH0 = 1;
  localparam int RST_HALF_CH1 = 5;
  localparam int RST_HALF_CH2 = 50;

  typedef enum logic [1:0] {
    STOPPED  = 2'd0,
    RUNNING  = 2'd1,
    DRAINING = 2'd2
  } chan_state_t;

  function automatic int reset_half(input int ch);
    case (ch)
      0:       return RST_HALF_CH0;
      1:       return RST_HALF_CH1;
      2:       return RST_HALF_CH2;
      default: return 1;
    endcase
  endfunction

endpackage

// File: rtl/freq_div_chan.sv
// One divider channel: half-period counter, output toggle, one-deep update slot
// that is applied only at a falling boundary or while the channel is stopped.
module freq_div_chan
  import freq_div_pkg::*;
#(
  parameter int               CNT_W    = freq_div_pkg::CNT_W,
  parameter logic [CNT_W-1:0] RST_HALF = CNT_W'(1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_half,
  output logic             clk_out,
  output logic             tick,
  output logic             pending
);

  chan_state_t      state_q, state_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] slot_q, slot_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             pend_q, pend_d;
  logic             wrap;

  assign wrap = (cnt_q == half_q - CNT_W'(1));

  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    cnt_d   = cnt_q;
    slot_d  = slot_q;
    clk_d   = clk_q;
    tick_d  = 1'b0;
    pend_d  = pend_q;

    case (state_q)
      STOPPED: begin
        clk_d = 1'b0;
        cnt_d = '0;
        if (pend_q) begin
          half_d = slot_q;
          pend_d = 1'b0;
        end else if (en && (half_q != '0)) begin
          state_d = RUNNING;
        end
      end

      RUNNING, DRAINING: begin
        if (!clk_q && !en) begin
          state_d = STOPPED;
          cnt_d   = '0;
        end else begin
          // A disable seen during the high phase is latched so the phase still runs full length
          if (clk_q && !en) state_d = DRAINING;
          if (wrap) begin
            cnt_d = '0;
            clk_d = ~clk_q;
            if (clk_q) begin
              if (state_d == DRAINING) state_d = STOPPED;
              if (pend_q) begin
                half_d = slot_q;
                pend_d = 1'b0;
                if (slot_q == '0) state_d = STOPPED;
              end
            end else begin
              tick_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      default: state_d = STOPPED;
    endcase

    if (wr) begin
      slot_d = wr_half;
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= STOPPED;
      half_q  <= RST_HALF;
      cnt_q   <= '0;
      slot_q  <= '0;
      clk_q   <= 1'b0;
      tick_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      clk_q   <= clk_d;
      tick_q  <= tick_d;
      pend_q  <= pend_d;
    end
  end

  assign clk_out = clk_q;
  assign tick    = tick_q;
  assign pending = pend_q;

endmodule

// File: rtl/freq_div_ctrl.sv
// Multi-channel programmable clock divider: one shared configuration port,
// NUM_CH independent channels and a reset synchronizer for clean release.
module freq_div_ctrl
  import freq_div_pkg::*;
#(
  parameter int CNT_W  = freq_div_pkg::CNT_W,
  parameter int NUM_CH = freq_div_pkg::NUM_CH
) (
  input  logic              CLK_in,
  input  logic              RST_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [1:0]        cfg_ch,
  input  logic [CNT_W-1:0]  cfg_half,
  input  logic [NUM_CH-1:0] en,
  output logic [NUM_CH-1:0] CLK_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pending
);

  logic [1:0]        rst_sync_q, rst_sync_d;
  logic              rst_n_int;
  logic [NUM_CH-1:0] wr_sel;

  // Assertion is immediate; release reaches the channels two edges later
  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
  end

  always_ff @(posedge CLK_in or negedge RST_n) begin
    if (!RST_n) rst_sync_q <= '0;
    else        rst_sync_q <= rst_sync_d;
  end

  assign rst_n_int = rst_sync_q[1];

  always_comb begin
    cfg_ready = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(cfg_ch) == i) cfg_ready = ~pending[i];
    end
  end

  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_sel[i] = cfg_valid && cfg_ready && (int'(cfg_ch) == i);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    freq_div_chan #(
      .CNT_W    (CNT_W),
      .RST_HALF (CNT_W'(reset_half(g)))
    ) u_chan (
      .clk     (CLK_in),
      .rst_n   (rst_n_int),
      .en      (en[g]),
      .wr      (wr_sel[g]),
      .wr_half (cfg_half),
      .clk_out (CLK_out[g]),
      .tick    (tick[g]),
      .pending (pending[g])
    );
  end

endmodule

// File: tb/tb_freq_div_ctrl.sv
// Self-checking bench for freq_div_ctrl: a vector table, directed multi-cycle
// sequences measured from recorded output history, and a randomized run against a countdown model.
module tb_freq_div_ctrl;

  localparam int W    = 8;
  localparam int N    = 3;
  localparam int HIST = 4096;

  logic         clock = 1'b0;
  logic         rstN;
  logic         cfgValid;
  logic         cfgReady;
  logic [1:0]   cfgCh;
  logic [W-1:0] cfgHalf;
  logic [N-1:0] en;
  logic [N-1:0] clkOut;
  logic [N-1:0] tick;
  logic [N-1:0] pending;

  always #5 clock = ~clock;

  freq_div_ctrl #(.CNT_W(W), .NUM_CH(N)) dut (
    .CLK_in    (clock),
    .RST_n     (rstN),
    .cfg_valid (cfgValid),
    .cfg_ready (cfgReady),
    .cfg_ch    (cfgCh),
    .cfg_half  (cfgHalf),
    .en        (en),
    .CLK_out   (clkOut),
    .tick      (tick),
    .pending   (pending)
  );

  int nChecks = 0;
  int nFails  = 0;
  int cyc     = 0;

  logic [N-1:0] clkHist  [HIST];
  logic [N-1:0] tickHist [HIST];
  logic [N-1:0] pendHist [HIST];

  typedef struct {
    logic         v;
    logic [1:0]   ch;
    logic [W-1:0] half;
    logic         expReady;
    logic [N-1:0] expPend;
  } vec_t;

  vec_t tbl[8];

  // Reference model: per channel, cycles remaining until the next toggle
  int rstH[N] = '{1, 5, 50};
  int mH[N];
  int mRem[N];
  int mSlot[N];
  bit mLvl[N];
  bit mRun[N];
  bit mStop[N];
  bit mPend[N];
  bit mTick[N];

  task automatic checkOutput(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] ch,
                               input logic [W-1:0] half, input logic [N-1:0] e);
    cfgValid = v;
    cfgCh    = ch;
    cfgHalf  = half;
    en       = e;
  endtask

  // Advance one clock and record the outputs seen just after the edge
  task automatic stepRec();
    @(posedge clock);
    #1;
    cyc++;
    if (cyc < HIST) begin
      clkHist[cyc]  = clkOut;
      tickHist[cyc] = tick;
      pendHist[cyc] = pending;
    end
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 2'd0, '0, '0);
    rstN = 1'b0;
    repeat (3) stepRec();
    rstN = 1'b1;
    repeat (3) stepRec();
  endtask

  // First sample after 'from' where the channel output changed in the given direction
  function automatic int findEdge(input int ch, input int from, input bit rising);
    if (from < 0) return -1;
    for (int c = from + 1; c <= cyc && c < HIST; c++) begin
      if (clkHist[c][ch] == rising && clkHist[c-1][ch] != rising) return c;
    end
    return -1;
  endfunction

  function automatic int tickErrors(input int ch, input int from, input int to);
    int errs = 0;
    for (int c = from + 1; c <= to && c < HIST; c++) begin
      if (tickHist[c][ch] != (clkHist[c][ch] & ~clkHist[c-1][ch])) errs++;
    end
    return errs;
  endfunction

  function automatic int countTicks(input int ch, input int from, input int to);
    int n = 0;
    for (int c = from + 1; c <= to && c < HIST; c++) begin
      if (tickHist[c][ch]) n++;
    end
    return n;
  endfunction

  function automatic void modelReset();
    for (int i = 0; i < N; i++) begin
      mH[i] = rstH[i]; mRem[i] = 0; mSlot[i] = 0;
      mLvl[i] = 0; mRun[i] = 0; mStop[i] = 0; mPend[i] = 0; mTick[i] = 0;
    end
  endfunction

  function automatic bit modelReady(input int ch);
    return (ch < N) ? !mPend[ch] : 1'b0;
  endfunction

  function automatic void modelStep(input bit v, input int ch, input int half, input logic [N-1:0] e);
    bit acc;
    acc = v && modelReady(ch);
    for (int i = 0; i < N; i++) begin
      mTick[i] = 0;
      if (!mRun[i]) begin
        if (mPend[i]) begin
          mH[i] = mSlot[i]; mPend[i] = 0;
        end else if (e[i] && mH[i] > 0) begin
          mRun[i] = 1; mRem[i] = mH[i]; mLvl[i] = 0; mStop[i] = 0;
        end
      end else if (!mLvl[i] && !e[i]) begin
        mRun[i] = 0;
      end else begin
        if (mLvl[i] && !e[i]) mStop[i] = 1;
        mRem[i]--;
        if (mRem[i] == 0) begin
          if (!mLvl[i]) begin
            mLvl[i] = 1; mTick[i] = 1; mRem[i] = mH[i];
          end else begin
            mLvl[i] = 0;
            if (mPend[i]) begin
              mH[i] = mSlot[i]; mPend[i] = 0;
            end
            mRem[i] = mH[i];
            if (mH[i] == 0 || mStop[i]) mRun[i] = 0;
          end
        end
      end
      if (acc && ch == i) begin
        mSlot[i] = half; mPend[i] = 1;
      end
    end
  endfunction

  function automatic logic [N-1:0] modelClk();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = mLvl[i];
    return r;
  endfunction

  function automatic logic [N-1:0] modelTick();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = mTick[i];
    return r;
  endfunction

  function automatic logic [N-1:0] modelPend();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = mPend[i];
    return r;
  endfunction

  // Hard stop if something stalls; every wait below is already bounded
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int base, e0, r, r2, f, f1, w, bad, k;
    logic [N-1:0] pBefore, curEn;
    int hs[N];

    rstN = 1'b0;
    applyStimulus(1'b0, 2'd0, '0, '0);
    clkHist[0] = '0; tickHist[0] = '0; pendHist[0] = '0;

    // Configuration decode with every channel stopped
    tbl = '{
      '{1'b1, 2'd3, 8'd7, 1'b0, 3'b000},
      '{1'b0, 2'd0, 8'd0, 1'b1, 3'b000},
      '{1'b1, 2'd1, 8'd4, 1'b1, 3'b010},
      '{1'b1, 2'd1, 8'd9, 1'b0, 3'b000},
      '{1'b1, 2'd0, 8'd2, 1'b1, 3'b001},
      '{1'b0, 2'd2, 8'd0, 1'b1, 3'b000},
      '{1'b1, 2'd2, 8'd0, 1'b1, 3'b100},
      '{1'b1, 2'd3, 8'd0, 1'b0, 3'b000}
    };

    doReset();
    checkOutput("resetOutputs", int'({clkOut, tick, pending}), 0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(tbl[i].v, tbl[i].ch, tbl[i].half, 3'b000);
      #1;
      checkOutput($sformatf("tbl%0d.ready", i), cfgReady, tbl[i].expReady);
      stepRec();
      checkOutput($sformatf("tbl%0d.pending", i), pending, tbl[i].expPend);
      checkOutput($sformatf("tbl%0d.idleOut", i), int'({clkOut, tick}), 0);
    end

    // Table left ch0 at H=2, ch1 at H=4 (the 9 was refused), ch2 at H=0
    base = cyc;
    applyStimulus(1'b0, 2'd0, '0, 3'b111);
    e0 = base + 1;
    repeat (14) stepRec();
    checkOutput("tblH.ch0FirstRise", findEdge(0, base, 1) - e0, 2);
    checkOutput("tblH.ch1FirstRise", findEdge(1, base, 1) - e0, 4);
    checkOutput("tblH.ch2Stopped", findEdge(2, base, 1), -1);

    // Reset defaults: divide by 2, 10 and 100
    doReset();
    base = cyc;
    applyStimulus(1'b0, 2'd0, '0, 3'b111);
    e0 = base + 1;
    repeat (210) stepRec();
    hs = '{1, 5, 50};
    for (int ch = 0; ch < N; ch++) begin
      r  = findEdge(ch, base, 1);
      f  = findEdge(ch, r, 0);
      r2 = findEdge(ch, r, 1);
      checkOutput($sformatf("dflt.ch%0dFirstRise", ch), r - e0, hs[ch]);
      checkOutput($sformatf("dflt.ch%0dHigh", ch), f - r, hs[ch]);
      checkOutput($sformatf("dflt.ch%0dPeriod", ch), r2 - r, 2 * hs[ch]);
      checkOutput($sformatf("dflt.ch%0dTick", ch), tickErrors(ch, base, cyc), 0);
    end

    // Ch1 update written two cycles into a high phase
    k = 0;
    while (k < 40 && !(clkHist[cyc][1] && !clkHist[cyc-1][1])) begin
      stepRec();
      k++;
    end
    checkOutput("upd.riseSeen", int'(clkHist[cyc][1] & ~clkHist[cyc-1][1]), 1);
    r = cyc;
    repeat (2) stepRec();
    applyStimulus(1'b1, 2'd1, 8'd3, 3'b111);
    #1;
    checkOutput("upd.ready", cfgReady, 1);
    stepRec();
    w = cyc;
    checkOutput("upd.pendSet", pending[1], 1);
    applyStimulus(1'b1, 2'd1, 8'd7, 3'b111);
    #1;
    checkOutput("upd.busyReady", cfgReady, 0);
    stepRec();
    applyStimulus(1'b1, 2'd0, 8'd2, 3'b111);
    #1;
    checkOutput("upd.ch0Ready", cfgReady, 1);
    stepRec();
    applyStimulus(1'b0, 2'd0, '0, 3'b111);
    repeat (60) stepRec();
    f  = findEdge(1, r, 0);
    r2 = findEdge(1, f, 1);
    f1 = findEdge(1, r2, 0);
    checkOutput("upd.oldHigh", f - r, 5);
    bad = 0;
    for (int c = w; c < f && c < HIST; c++) if (!pendHist[c][1]) bad++;
    if (f > 0 && pendHist[f][1]) bad++;
    checkOutput("upd.pendWindow", bad, 0);
    checkOutput("upd.newLow", r2 - f, 3);
    checkOutput("upd.newHigh", f1 - r2, 3);
    checkOutput("upd.newPeriod", findEdge(1, r2, 1) - r2, 6);
    r = findEdge(0, w + 8, 1);
    checkOutput("upd.ch0Period", findEdge(0, r, 1) - r, 4);

    // Ch2 disabled ten cycles into its high phase
    k = 0;
    while (k < 120 && !(clkHist[cyc][2] && !clkHist[cyc-1][2])) begin
      stepRec();
      k++;
    end
    checkOutput("drain.riseSeen", int'(clkHist[cyc][2] & ~clkHist[cyc-1][2]), 1);
    r = cyc;
    repeat (9) stepRec();
    applyStimulus(1'b0, 2'd0, '0, 3'b011);
    repeat (130) stepRec();
    f = findEdge(2, r, 0);
    checkOutput("drain.fullHigh", f - r, 50);
    checkOutput("drain.noRise", findEdge(2, f, 1), -1);
    checkOutput("drain.noTick", countTicks(2, f, cyc), 0);
    checkOutput("drain.outLow", clkOut[2], 0);

    // Out-of-range channel, then H=0 stop on ch0
    pBefore = pending;
    applyStimulus(1'b1, 2'd3, 8'd5, 3'b011);
    #1;
    checkOutput("badCh.ready", cfgReady, 0);
    stepRec();
    checkOutput("badCh.pending", pending, pBefore);
    applyStimulus(1'b1, 2'd0, 8'd0, 3'b011);
    #1;
    checkOutput("stop.ready", cfgReady, 1);
    stepRec();
    w = cyc;
    applyStimulus(1'b0, 2'd0, '0, 3'b011);
    repeat (20) stepRec();
    f = findEdge(0, w, 0);
    checkOutput("stop.fallSoon", int'(f > w && f - w <= 4), 1);
    checkOutput("stop.noRise", findEdge(0, f, 1), -1);
    checkOutput("stop.finalState", int'({clkOut[0], pending[0]}), 0);

    // Reset with a pending update on ch1 (now at H=3)
    k = 0;
    while (k < 20 && !(!clkHist[cyc][1] && clkHist[cyc-1][1])) begin
      stepRec();
      k++;
    end
    checkOutput("rstPend.fallSeen", int'(~clkHist[cyc][1] & clkHist[cyc-1][1]), 1);
    applyStimulus(1'b1, 2'd1, 8'd7, 3'b011);
    #1;
    checkOutput("rstPend.ready", cfgReady, 1);
    stepRec();
    applyStimulus(1'b0, 2'd1, '0, 3'b011);
    stepRec();
    checkOutput("rstPend.pendBefore", pending[1], 1);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("rstPend.outputsCleared", int'({clkOut, tick, pending}), 0);
    checkOutput("rstPend.readyInReset", cfgReady, 1);
    cfgCh = 2'd3;
    #1;
    checkOutput("rstPend.badChInReset", cfgReady, 0);
    cfgCh = 2'd1;
    repeat (3) stepRec();
    rstN = 1'b1;
    base = cyc;
    repeat (40) stepRec();
    r  = findEdge(1, base, 1);
    f  = findEdge(1, r, 0);
    r2 = findEdge(1, r, 1);
    checkOutput("rstPend.high", f - r, 5);
    checkOutput("rstPend.period", r2 - r, 10);

    // Randomized run against the countdown model
    doReset();
    modelReset();
    curEn = 3'b111;
    for (int n = 0; n < 3000; n++) begin
      bit v;
      int ch, half;
      if ($urandom_range(0, 15) == 0) curEn = curEn ^ (3'b001 << $urandom_range(0, 2));
      v    = ($urandom_range(0, 2) == 0);
      ch   = $urandom_range(0, 3);
      half = $urandom_range(0, 6);
      applyStimulus(v, 2'(ch), W'(half), curEn);
      #1;
      checkOutput("rnd.ready", cfgReady, modelReady(ch));
      checkOutput("rnd.clkOut", clkOut, modelClk());
      checkOutput("rnd.tick", tick, modelTick());
      checkOutput("rnd.pending", pending, modelPend());
      modelStep(v, ch, half, curEn);
      stepRec();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/freq_div_ctrl.md
FREQ_DIV_CTRL -- requirements
Module: freq_div_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, giving the half-period counter and register width.
REQ-002 The block SHALL have parameter NUM_CH, default 3, giving the number of divider channels.
REQ-003 The block SHALL have port CLK_in, input, width 1: the single source clock; all logic is on its rising edge.
REQ-004 The block SHALL have port RST_n, input, width 1: reset, asynchronous and active-low.
REQ-005 The block SHALL have port cfg_valid, input, width 1: configuration request.
REQ-006 The block SHALL have port cfg_ready, output, width 1: the configuration request can be accepted.
REQ-007 The block SHALL have port cfg_ch, input, width 2: target channel index.
REQ-008 The block SHALL have port cfg_half, input, width CNT_W: new half-period in CLK_in cycles.
REQ-009 The block SHALL have port en, input, width NUM_CH: per-channel run enable.
REQ-010 The block SHALL have port CLK_out, output, width NUM_CH: divided clocks, registered.
REQ-011 The block SHALL have port tick, output, width NUM_CH: one-cycle pulse, coincident with each CLK_out rising transition.
REQ-012 The block SHALL have port pending, output, width NUM_CH: an accepted configuration is not yet applied.

Function
REQ-013 Each channel SHALL hold an active half-period H, a counter and a pending slot; while running, CLK_out[i] toggles every H CLK_in cycles, giving a divide ratio of 2H.
REQ-014 Running channel: counter counts 0..H-1, toggles CLK_out[i] and wraps to 0 at H-1; H=1 gives divide-by-2.
REQ-015 cfg_ready SHALL be 1 iff cfg_ch < NUM_CH and pending[cfg_ch]=0; it is purely combinational from those inputs and that state.
REQ-016 A transfer SHALL occur on a cycle with cfg_valid=1 and cfg_ready=1; it stores cfg_half in the slot and sets pending[cfg_ch] on the next edge.
REQ-017 A request to cfg_ch >= NUM_CH SHALL never be accepted, and SHALL leave all state unchanged.
REQ-018 A pending value SHALL be applied only at a period boundary: the edge where CLK_out[i] goes 1->0. At that edge, H is loaded, the counter is cleared and pending[i] is cleared.
REQ-019 If the channel is stopped (CLK_out[i]=0, not running), a pending value SHALL apply on the edge after the transfer (pending visible for exactly one cycle).
REQ-020 H=0 SHALL mean stop: once it is applied, CLK_out[i] is held 0 and the counter is held at 0.
REQ-021 en[i] deasserted SHALL stop the channel at the next 1->0 boundary; if CLK_out[i] is already 0, it stops on the next edge. The output SHALL never shorten a high phase.
REQ-022 en[i] asserted with H>=1 SHALL start the channel from counter 0 and CLK_out=0; the first rise occurs H cycles later.
REQ-023 A boundary edge coinciding with a transfer to the same channel is impossible by REQ-015. A transfer to channel j coinciding with a boundary on channel i (i != j) SHALL proceed independently.
REQ-024 tick[i] SHALL be 1 for exactly the cycle after each 0->1 toggle, aligned with CLK_out[i]=1.
REQ-025 Channels SHALL be fully independent; no arbitration exists other than the single config port.

Reset
REQ-026 While RST_n=0, CLK_out, tick, pending, counters and slots SHALL be 0, and cfg_ready SHALL follow REQ-015.
REQ-027 Reset SHALL set the active H for channels 0/1/2 to 1/5/50, so a 100 MHz CLK_in gives 50/10/1 MHz outputs once enabled.
REQ-028 Reset asserted mid-period or with a pending update SHALL discard the update; release SHALL be synchronous to CLK_in.

Structure
REQ-029 Package freq_div_pkg SHALL hold CNT_W, NUM_CH, the reset half-period constants (1, 5, 50) and a channel-state typedef (STOPPED, RUNNING, DRAINING).
REQ-030 One sub-module, freq_div_chan, SHALL implement a single channel (counter, toggle, slot, state). The top SHALL instantiate NUM_CH copies and decode cfg_ready.

Verification
REQ-031 Reset, then en=3'b111 -> CLK_out periods of 2, 10 and 100 cycles; first rises at cycles 1, 5 and 50 after enable.
REQ-032 Ch1 running at H=5, write H=3 mid-high -> the current period completes at 10 cycles, the next periods are 6 cycles, and pending stays 1 until that boundary.
REQ-033 A second write to ch1 while pending -> cfg_ready=0 and the value is ignored; a simultaneous write to ch0 is accepted.
REQ-034 Deassert en[2] 10 cycles into the high phase (H=50) -> the high phase lasts the full 50 cycles, then the output stays 0 and tick stops.
REQ-035 Write cfg_ch=3 -> cfg_ready=0 and no state changes. Write H=0 to ch0 -> ch0 stops low at the next boundary.
REQ-036 Assert RST_n=0 mid-period with pending=1 -> all outputs are 0 immediately, and after release ch1 runs at H=5, not the pending value.
